wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of entries in the multicycle result queue (power of two, at least 2).
REQ-002 Parameter STARVE_LIMIT, default 4: number of consecutive blocked cycles before a drain stall is forced.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 pipe_we_in / pipe_addr_in / pipe_data_in  in  1/5/32  writeback request from the wb_stage outputs.
REQ-006 mc_valid_in / mc_addr_in / mc_data_in  in  1/5/32  result offered by the multicycle unit (mul/div).
REQ-007 mc_ready_out  out  1  result accepted this cycle when mc_valid_in and mc_ready_out are both high.
REQ-008 stall_req_out  out  1  requests that the pipeline hold MEM/WB for one cycle.
REQ-009 rs1_addr_in / rs2_addr_in  in  5/5  source register addresses from the ID stage.
REQ-010 pend_hit_out  out  1  a nonzero rs1 or rs2 matches a queued destination.
REQ-011 wb_write_en_out / wb_write_addr_out / wb_write_data_out  out  1/5/32  register-file write port.

Function
REQ-012 The pipeline request has priority: when pipe_we_in=1, pipe_addr_in!=0 and stall_req_out=0, the outputs shall equal the pipeline request in the same cycle (combinational, 0 latency).
REQ-013 While stall_req_out=1, pipe_we_in shall be ignored; the pipeline re-presents the same request in the next cycle.
REQ-014 If the port is not taken by the pipeline and the queue is non-empty, the head entry shall be written and popped in that cycle.
REQ-015 Bypass: if the port is free, the queue is empty and an mc handshake occurs, mc data shall be written in the same cycle without being enqueued.
REQ-016 Otherwise an accepted mc result shall be enqueued at the tail.
REQ-017 Ordering is strictly FIFO; same-rd entries are never reordered or merged.
REQ-018 mc_ready_out = !full.
REQ-019 A simultaneous pop and push when full is not possible, because ready is low; a pop and push in the same cycle otherwise keeps the count unchanged.
REQ-020 Writes to x0 (from either source) shall produce wb_write_en_out=0.
   - An x0 mc result is accepted but never enqueued.
   - A pipeline x0 write does not occupy the port.
REQ-021 Starvation counter: increments each cycle the queue is non-empty and the head is not popped; clears on a pop or when the queue is empty.
REQ-022 Stall FSM, NORMAL -> STALL when the counter reaches STARVE_LIMIT-1 and is still blocked.
   - STALL lasts exactly one cycle, asserts stall_req_out, pops the head, and returns to NORMAL with the counter at 0.
REQ-023 pend_hit_out shall compare rs1/rs2 against all valid queue entries combinationally; an address of 0 never hits.
REQ-024 When wb_write_en_out=0, wb_write_addr_out and wb_write_data_out shall be 0.

Reset
REQ-025 While rst_n=0: queue empty, counter 0, FSM in NORMAL.
REQ-026 While rst_n=0, every output is gated to 0: wb_write_en_out, stall_req_out, mc_ready_out, pend_hit_out.
REQ-027 Reset mid-operation discards all queued entries; the first cycle after release behaves as an empty queue.

Structure
REQ-028 The shared package shall hold the constants XLEN=32 and REG_ADDR_W=5, and the stall FSM state enum {NORMAL, STALL}.
REQ-029 The queue shall be a separate sub-module wb_result_fifo (DEPTH-entry storage, push/pop, full/empty, per-entry address compare outputs).
REQ-030 The arbitration, counter and FSM reside in wb_port_arbiter.

Verification
REQ-031 Bypass: queue empty, pipe_we=0, mc write to x5 of 0x1234 -> same-cycle write of x5=0x1234 and ready=1.
REQ-032 Collision: pipe write x3=0xA and mc write x7=0xB in the same cycle -> x3 written first, x7 written the next cycle, queue empty afterwards.
REQ-033 Starvation: one entry queued and pipe_we=1 every cycle, STARVE_LIMIT=4 -> stall_req_out high exactly in the 5th cycle, entry written in that cycle, pipe write resumes the next cycle.
REQ-034 Full: DEPTH=2, pipe_we continuously high, two mc results accepted -> mc_ready_out=0; a third valid is held until a pop occurs.
REQ-035 Hazard/x0: queued x9 with rs1=9 -> pend_hit_out=1; rs1=0 -> 0; an mc write to x0 -> accepted, no enable, pend_hit_out=0.
REQ-036 Reset while two entries are queued -> all outputs 0 immediately; after release mc_ready_out=1 and no stale write appears.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared constants, stall FSM state type and small helpers for the register-file
// write-port arbiter and its multicycle result queue.
//   XLEN        : register data width
//   REG_ADDR_W  : register address width
//   stall_state_e : NORMAL / STALL states of the starvation stall FSM
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      STALL  = 1'b1
   } stall_state_e;

   // True when the register address names a real register (x0 is hardwired).
   function automatic logic addr_live(input logic [REG_ADDR_W-1:0] addr);
      return (addr != {REG_ADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// DEPTH-entry FIFO holding multicycle results (destination + data) waiting for
// the register-file write port. Provides per-entry address compare outputs so
// the ID stage can detect hazards against every pending destination.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   push, push_addr, push_data : enqueue at the tail (ignored when full)
//   pop                        : drop the head entry (ignored when empty)
//   head_addr, head_data       : current head entry
//   full, empty                : occupancy flags
//   cmp_addr_a, cmp_addr_b     : addresses compared against every entry
//   hit_a, hit_b               : per-entry match of a valid entry
// -----------------------------------------------------------------------------
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_addr,
   input  logic [XLEN-1:0]       push_data,
   input  logic                  pop,
   output logic [REG_ADDR_W-1:0] head_addr,
   output logic [XLEN-1:0]       head_data,
   output logic                  full,
   output logic                  empty,
   input  logic [REG_ADDR_W-1:0] cmp_addr_a,
   input  logic [REG_ADDR_W-1:0] cmp_addr_b,
   output logic [DEPTH-1:0]      hit_a,
   output logic [DEPTH-1:0]      hit_b
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_ADDR_W-1:0] addr_mem_r [DEPTH];
   logic [XLEN-1:0]       data_mem_r [DEPTH];
   logic [DEPTH-1:0]      valid_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign head_addr = addr_mem_r[rd_ptr_r];
   assign head_data = data_mem_r[rd_ptr_r];

   // Storage, valid bits and pointers; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_r[i] <= {REG_ADDR_W{1'b0}};
            data_mem_r[i] <= {XLEN{1'b0}};
         end
         valid_r  <= {DEPTH{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         // Pop and push never target the same slot: that needs empty or full.
         if (pop_ok_s) begin
            valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
         end
         if (push_ok_s) begin
            valid_r[wr_ptr_r]    <= 1'b1;
            addr_mem_r[wr_ptr_r] <= push_addr;
            data_mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy count; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Per-entry hazard compare against valid entries only.
   always_comb begin
      hit_a = {DEPTH{1'b0}};
      hit_b = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         hit_a[i] = valid_r[i] && (addr_mem_r[i] == cmp_addr_a);
         hit_b[i] = valid_r[i] && (addr_mem_r[i] == cmp_addr_b);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (priority, zero latency) and the multicycle unit. Multicycle results
// that cannot be written immediately wait in wb_result_fifo; if the queue head
// is blocked for STARVE_LIMIT cycles a one-cycle pipeline stall drains it.
// Ports:
//   clk, rst_n                                   : clock, async active-low reset
//   pipe_we_in/pipe_addr_in/pipe_data_in         : pipeline writeback request
//   mc_valid_in/mc_addr_in/mc_data_in            : multicycle result offer
//   mc_ready_out                                 : multicycle result accepted
//   stall_req_out                                : hold MEM/WB for one cycle
//   rs1_addr_in/rs2_addr_in                      : ID-stage source registers
//   pend_hit_out                                 : source matches a queued rd
//   wb_write_en_out/_addr_out/_data_out          : register-file write port
// -----------------------------------------------------------------------------
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_we_in,
   input  logic [REG_ADDR_W-1:0] pipe_addr_in,
   input  logic [XLEN-1:0]       pipe_data_in,
   input  logic                  mc_valid_in,
   input  logic [REG_ADDR_W-1:0] mc_addr_in,
   input  logic [XLEN-1:0]       mc_data_in,
   output logic                  mc_ready_out,
   output logic                  stall_req_out,
   input  logic [REG_ADDR_W-1:0] rs1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs2_addr_in,
   output logic                  pend_hit_out,
   output logic                  wb_write_en_out,
   output logic [REG_ADDR_W-1:0] wb_write_addr_out,
   output logic [XLEN-1:0]       wb_write_data_out
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   stall_state_e          state_r;
   stall_state_e          state_next_s;
   logic [CNT_W-1:0]      starve_cnt_r;
   logic [CNT_W-1:0]      starve_cnt_next_s;

   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [REG_ADDR_W-1:0] head_addr_s;
   logic [XLEN-1:0]       head_data_s;
   logic [DEPTH-1:0]      hit_a_s;
   logic [DEPTH-1:0]      hit_b_s;

   logic                  pipe_take_s;
   logic                  mc_fire_s;
   logic                  mc_live_s;
   logic                  pop_s;
   logic                  bypass_s;
   logic                  push_s;
   logic                  blocked_s;

   logic                  wr_en_s;
   logic [REG_ADDR_W-1:0] wr_addr_s;
   logic [XLEN-1:0]       wr_data_s;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_s),
      .push_addr  (mc_addr_in),
      .push_data  (mc_data_in),
      .pop        (pop_s),
      .head_addr  (head_addr_s),
      .head_data  (head_data_s),
      .full       (fifo_full_s),
      .empty      (fifo_empty_s),
      .cmp_addr_a (rs1_addr_in),
      .cmp_addr_b (rs2_addr_in),
      .hit_a      (hit_a_s),
      .hit_b      (hit_b_s)
   );

   // Port ownership: the pipeline wins unless stalled or writing x0; otherwise
   // the queue head drains, and an empty queue lets a fresh mc result bypass.
   always_comb begin
      pipe_take_s = pipe_we_in && addr_live(pipe_addr_in) && (state_r == NORMAL);
      mc_fire_s   = mc_valid_in && !fifo_full_s;
      mc_live_s   = mc_fire_s && addr_live(mc_addr_in);
      pop_s       = !pipe_take_s && !fifo_empty_s;
      bypass_s    = !pipe_take_s && fifo_empty_s && mc_live_s;
      push_s      = mc_live_s && !bypass_s;
      blocked_s   = !fifo_empty_s && !pop_s;
   end

   // Write-port mux; address and data are forced to zero whenever no write occurs.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = {REG_ADDR_W{1'b0}};
      wr_data_s = {XLEN{1'b0}};
      if (!rst_n) begin
         wr_en_s   = 1'b0;
      end else if (pipe_take_s) begin
         wr_en_s   = 1'b1;
         wr_addr_s = pipe_addr_in;
         wr_data_s = pipe_data_in;
      end else if (!fifo_empty_s) begin
         wr_en_s   = 1'b1;
         wr_addr_s = head_addr_s;
         wr_data_s = head_data_s;
      end else if (bypass_s) begin
         wr_en_s   = 1'b1;
         wr_addr_s = mc_addr_in;
         wr_data_s = mc_data_in;
      end else begin
         wr_en_s   = 1'b0;
      end
   end

   // Starvation counter and stall FSM next state.
   always_comb begin
      state_next_s      = state_r;
      starve_cnt_next_s = starve_cnt_r;
      case (state_r)
         NORMAL: begin
            if (blocked_s && (starve_cnt_r == CNT_W'(STARVE_LIMIT - 1))) begin
               state_next_s      = STALL;
               starve_cnt_next_s = {CNT_W{1'b0}};
            end else if (blocked_s) begin
               starve_cnt_next_s = starve_cnt_r + CNT_W'(1);
            end else begin
               starve_cnt_next_s = {CNT_W{1'b0}};
            end
         end
         STALL: begin
            // The stall cycle always pops the head, so the count restarts.
            state_next_s      = NORMAL;
            starve_cnt_next_s = {CNT_W{1'b0}};
         end
         default: begin
            state_next_s      = NORMAL;
            starve_cnt_next_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Stall FSM and starvation counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= NORMAL;
         starve_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_next_s;
         starve_cnt_r <= starve_cnt_next_s;
      end
   end

   assign wb_write_en_out   = wr_en_s;
   assign wb_write_addr_out = wr_addr_s;
   assign wb_write_data_out = wr_data_s;
   assign mc_ready_out      = rst_n && !fifo_full_s;
   assign stall_req_out     = rst_n && (state_r == STALL);
   // x0 is never a hazard; queued entries are never x0 but sources may be.
   assign pend_hit_out      = rst_n &&
                              ((addr_live(rs1_addr_in) && (|hit_a_s)) ||
                               (addr_live(rs2_addr_in) && (|hit_b_s)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        pipe_we_in;
   logic [4:0]  pipe_addr_in;
   logic [31:0] pipe_data_in;
   logic        mc_valid_in;
   logic [4:0]  mc_addr_in;
   logic [31:0] mc_data_in;
   logic        mc_ready_out;
   logic        stall_req_out;
   logic [4:0]  rs1_addr_in;
   logic [4:0]  rs2_addr_in;
   logic        pend_hit_out;
   logic        wb_write_en_out;
   logic [4:0]  wb_write_addr_out;
   logic [31:0] wb_write_data_out;

   int total;
   int bad;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pipe_we_in        (pipe_we_in),
      .pipe_addr_in      (pipe_addr_in),
      .pipe_data_in      (pipe_data_in),
      .mc_valid_in       (mc_valid_in),
      .mc_addr_in        (mc_addr_in),
      .mc_data_in        (mc_data_in),
      .mc_ready_out      (mc_ready_out),
      .stall_req_out     (stall_req_out),
      .rs1_addr_in       (rs1_addr_in),
      .rs2_addr_in       (rs2_addr_in),
      .pend_hit_out      (pend_hit_out),
      .wb_write_en_out   (wb_write_en_out),
      .wb_write_addr_out (wb_write_addr_out),
      .wb_write_data_out (wb_write_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {en, addr, data, ready, stall, hit}
   function automatic logic [40:0] obs();
      return {wb_write_en_out, wb_write_addr_out, wb_write_data_out,
              mc_ready_out, stall_req_out, pend_hit_out};
   endfunction

   task automatic idle_inputs();
      pipe_we_in   = 1'b0;
      pipe_addr_in = 5'd0;
      pipe_data_in = 32'd0;
      mc_valid_in  = 1'b0;
      mc_addr_in   = 5'd0;
      mc_data_in   = 32'd0;
      rs1_addr_in  = 5'd0;
      rs2_addr_in  = 5'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pipe_we_in = 1'b1; pipe_addr_in = 5'd3; pipe_data_in = 32'h5;
      mc_valid_in = 1'b1; mc_addr_in = 5'd5; mc_data_in = 32'h6;
      rs1_addr_in = 5'd5; rs2_addr_in = 5'd3;
      #2;
      total++;
      if (obs() !== 41'd0) begin
         bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), 41'd0);
      end
      next_cycle();
      total++;
      if (obs() !== 41'd0) begin
         bad++; $display("FAIL reset_held got=%h want=%h", obs(), 41'd0);
      end
      rst_n = 1'b1;
      idle_inputs();
      #2;
      total++;
      if (obs() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_release got=%h want=%h", obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
      end
      next_cycle();
   endtask

   task automatic test_bypass();
      mc_valid_in = 1'b1; mc_addr_in = 5'd5; mc_data_in = 32'h1234; rs1_addr_in = 5'd5;
      #2;
      total++;
      if (obs() !== {1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL bypass_write got=%h want=%h", obs(), {1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0});
      end
      next_cycle();
      idle_inputs(); rs1_addr_in = 5'd5;
      #2;
      total++;
      if (obs() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL bypass_not_queued got=%h want=%h", obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
      end
      next_cycle();
   endtask

   task automatic test_collision();
      logic [40:0] exp_v;
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         rs1_addr_in = 5'd7;
         case (k)
            0: begin
               pipe_we_in = 1'b1; pipe_addr_in = 5'd3; pipe_data_in = 32'hA;
               mc_valid_in = 1'b1; mc_addr_in = 5'd7; mc_data_in = 32'hB;
               exp_v = {1'b1, 5'd3, 32'hA, 1'b1, 1'b0, 1'b0};
            end
            1: exp_v = {1'b1, 5'd7, 32'hB, 1'b1, 1'b0, 1'b1};
            default: exp_v = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
         endcase
         #2;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL collision_c%0d got=%h want=%h", k, obs(), exp_v);
         end
         next_cycle();
      end
   endtask

   task automatic test_starvation();
      logic [40:0] exp_v;
      for (int k = 0; k < 7; k++) begin
         idle_inputs();
         pipe_we_in = 1'b1; pipe_addr_in = 5'd1; pipe_data_in = 32'h100 + 32'(k);
         rs1_addr_in = (k == 2) ? 5'd0 : 5'd9;
         if (k == 0) begin
            mc_valid_in = 1'b1; mc_addr_in = 5'd9; mc_data_in = 32'h99;
            exp_v = {1'b1, 5'd1, 32'h100, 1'b1, 1'b0, 1'b0};
         end else if (k == 5) begin
            exp_v = {1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1};
         end else if (k == 6) begin
            exp_v = {1'b1, 5'd1, 32'h106, 1'b1, 1'b0, 1'b0};
         end else begin
            exp_v = {1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 1'b0, (k == 2) ? 1'b0 : 1'b1};
         end
         #2;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL starve_c%0d got=%h want=%h", k, obs(), exp_v);
         end
         next_cycle();
      end
   endtask

   task automatic test_full();
      logic [40:0] exp_v;
      for (int k = 0; k < 10; k++) begin
         idle_inputs();
         if (k < 7) begin
            pipe_we_in = 1'b1; pipe_addr_in = 5'd2; pipe_data_in = 32'h200 + 32'(k);
            mc_valid_in = 1'b1;
            mc_addr_in = (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12;
            mc_data_in = (k == 0) ? 32'h10A : (k == 1) ? 32'h10B : 32'h10C;
         end
         case (k)
            0, 1:    exp_v = {1'b1, 5'd2, 32'h200 + 32'(k), 1'b1, 1'b0, 1'b0};
            2, 3, 4: exp_v = {1'b1, 5'd2, 32'h200 + 32'(k), 1'b0, 1'b0, 1'b0};
            5:       exp_v = {1'b1, 5'd10, 32'h10A, 1'b0, 1'b1, 1'b0};
            6:       exp_v = {1'b1, 5'd2, 32'h206, 1'b1, 1'b0, 1'b0};
            7:       exp_v = {1'b1, 5'd11, 32'h10B, 1'b0, 1'b0, 1'b0};
            8:       exp_v = {1'b1, 5'd12, 32'h10C, 1'b1, 1'b0, 1'b0};
            default: exp_v = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
         endcase
         #2;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL full_c%0d got=%h want=%h", k, obs(), exp_v);
         end
         next_cycle();
      end
   endtask

   task automatic test_x0();
      logic [40:0] exp_v;
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         case (k)
            0: begin
               pipe_we_in = 1'b1; pipe_addr_in = 5'd4; pipe_data_in = 32'h44;
               mc_valid_in = 1'b1; mc_addr_in = 5'd6; mc_data_in = 32'h66;
               exp_v = {1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0};
            end
            1: begin
               pipe_we_in = 1'b1; pipe_addr_in = 5'd0; pipe_data_in = 32'hDEAD;
               mc_valid_in = 1'b1; mc_addr_in = 5'd0; mc_data_in = 32'h77;
               rs1_addr_in = 5'd6;
               exp_v = {1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b1};
            end
            2: begin
               mc_valid_in = 1'b1; mc_addr_in = 5'd0; mc_data_in = 32'h55;
               exp_v = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
            end
            default: begin
               rs1_addr_in = 5'd6;
               exp_v = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
            end
         endcase
         #2;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL x0_c%0d got=%h want=%h", k, obs(), exp_v);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         idle_inputs();
         pipe_we_in = 1'b1; pipe_addr_in = 5'd1; pipe_data_in = 32'h300 + 32'(k);
         mc_valid_in = 1'b1; mc_addr_in = 5'd13 + 5'(k); mc_data_in = 32'h400 + 32'(k);
         next_cycle();
      end
      rst_n = 1'b0;
      mc_addr_in = 5'd15; rs1_addr_in = 5'd13; rs2_addr_in = 5'd14;
      #2;
      total++;
      if (obs() !== 41'd0) begin
         bad++; $display("FAIL midreset_outputs got=%h want=%h", obs(), 41'd0);
      end
      next_cycle();
      rst_n = 1'b1;
      idle_inputs(); rs1_addr_in = 5'd13; rs2_addr_in = 5'd14;
      for (int k = 0; k < 2; k++) begin
         #2;
         total++;
         if (obs() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midreset_release_c%0d got=%h want=%h", k, obs(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0});
         end
         next_cycle();
      end
   endtask

   // Random traffic against a queue-based reference of the arbitration rules.
   task automatic test_random();
      logic [4:0]  q_addr[$];
      logic [31:0] q_data[$];
      bit          m_stall;
      int          m_starve;
      logic [40:0] exp_v;
      bit          fire, popped, bypassed, hit;
      int          n;
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      rst_n = 1'b1;
      m_stall = 1'b0;
      m_starve = 0;
      for (int c = 0; c < 800; c++) begin
         pipe_we_in   = ($urandom_range(99) < 70);
         pipe_addr_in = 5'($urandom_range(7));
         pipe_data_in = $urandom;
         mc_valid_in  = ($urandom_range(99) < 50);
         mc_addr_in   = 5'($urandom_range(7));
         mc_data_in   = $urandom;
         rs1_addr_in  = 5'($urandom_range(7));
         rs2_addr_in  = 5'($urandom_range(7));
         n = q_addr.size();
         fire = mc_valid_in && (n < DEPTH);
         popped = 1'b0;
         bypassed = 1'b0;
         hit = 1'b0;
         foreach (q_addr[i]) begin
            if ((rs1_addr_in != 5'd0 && q_addr[i] == rs1_addr_in) ||
                (rs2_addr_in != 5'd0 && q_addr[i] == rs2_addr_in)) hit = 1'b1;
         end
         if (pipe_we_in && pipe_addr_in != 5'd0 && !m_stall) begin
            exp_v = {1'b1, pipe_addr_in, pipe_data_in, 1'b0, 1'b0, 1'b0};
         end else if (n > 0) begin
            exp_v = {1'b1, q_addr[0], q_data[0], 1'b0, 1'b0, 1'b0};
            popped = 1'b1;
         end else if (fire && mc_addr_in != 5'd0) begin
            exp_v = {1'b1, mc_addr_in, mc_data_in, 1'b0, 1'b0, 1'b0};
            bypassed = 1'b1;
         end else begin
            exp_v = 41'd0;
         end
         exp_v[2] = (n < DEPTH);
         exp_v[1] = m_stall;
         exp_v[0] = hit;
         #2;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL random_c%0d got=%h want=%h", c, obs(), exp_v);
         end
         if (popped) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
         end
         if (fire && mc_addr_in != 5'd0 && !bypassed) begin
            q_addr.push_back(mc_addr_in);
            q_data.push_back(mc_data_in);
         end
         if (n > 0 && !popped) begin
            if (!m_stall && m_starve == STARVE_LIMIT - 1) begin
               m_stall = 1'b1;
               m_starve = 0;
            end else begin
               m_starve++;
            end
         end else begin
            m_starve = 0;
            m_stall = 1'b0;
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      test_reset();
      test_bypass();
      test_collision();
      test_starvation();
      test_full();
      test_x0();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
